pixel_collector: RTL and testbench
==================================

Name: pixel_collector

Overview:
- Consumer end of the solver result interface.
- Accepts 4-bit iteration results from NUM_SOLVERS row-interleaved pattern solvers. Solver i handles rows i, i+NUM_SOLVERS, and so on, in raster order.
- Rebuilds each pixel's framebuffer address and writes pixels to framebuffer memory through a valid/ready write port.
- Solvers have no stall input, so the block buffers each solver's results, arbitrates between solvers round-robin, and flags any data loss.

Parameters:
- NUM_SOLVERS, 4, number of solvers feeding the block; solver i owns rows i + k*NUM_SOLVERS.
- NUM_COLUMNS, 640, pixels per row.
- NUM_ROWS, 480, rows per frame.
- FIFO_DEPTH, 4, entries per solver FIFO; must be a power of two and at least 2.
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= NUM_COLUMNS*NUM_ROWS.

Ports:
- clock  in  1  single system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  synchronous one-cycle pulse; clears frame state and begins a new frame, paired with the solvers' continue.
- solver_out  in  4*NUM_SOLVERS  packed results; solver i occupies bits [4i+3:4i].
- solver_ready  in  NUM_SOLVERS  one-cycle strobe; result i is valid on this cycle.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_WIDTH  pixel address, row*NUM_COLUMNS + column.
- wr_data  out  4  pixel value.
- frame_done  out  1  level; high once all NUM_COLUMNS*NUM_ROWS pixels have been written.
- overflow  out  1  sticky; high if any result was dropped.

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0. All FIFOs empty, round-robin pointer=0, pixel count=0. Solver i address counter = i*NUM_COLUMNS, column counter = 0.
- Capture: when solver_ready[i]=1, the value {addr_i, solver_out[i]} is pushed into FIFO i at that clock edge.
- Address counter i advances on every ready strobe, including dropped ones, so later pixels still land correctly:
  - column < NUM_COLUMNS-1: column+1, addr+1.
  - otherwise: column=0, addr += (NUM_SOLVERS-1)*NUM_COLUMNS + 1.
- Full FIFO: a push is accepted if the FIFO is not full, or if it is full and popped in the same cycle.
  - Otherwise the pixel is dropped and overflow is set; overflow stays set until reset or start.
- Output stage (registered):
  - When the output register is empty, or a transfer completes this cycle, the arbiter selects the first non-empty FIFO at or after the pointer. It pops that FIFO and loads wr_addr/wr_data, with wr_valid=1 next cycle.
  - The pointer then moves to the selected index + 1, modulo NUM_SOLVERS.
  - Minimum latency: strobe at cycle t gives wr_valid at t+1, when the FIFO and register are empty.
  - Sustained throughput with wr_ready held high is 1 pixel per cycle.
- Handshake: a transfer occurs when wr_valid && wr_ready. While wr_valid=1 and wr_ready=0, wr_addr/wr_data hold stable. wr_valid never drops without a transfer.
- Pixel count increments on each transfer. On the transfer that brings the count to NUM_COLUMNS*NUM_ROWS, frame_done goes to 1 on the next cycle and stays high until start or reset.
- Strobes arriving after frame_done are treated like any other strobe: pushed, or dropped with overflow.
- start: same-cycle synchronous clear of everything reset clears. start has priority over any same-cycle solver_ready, which is discarded, and over any pending write, which is abandoned with wr_valid=0 next cycle.
- Reset mid-frame: asynchronous clear of all state; there is no partial flush.
- Simultaneous strobes from all solvers are legal; each solver has its own FIFO.

Decomposition:
- Shared package contents:
  - PIXEL_WIDTH=4.
  - A framebuffer address-width constant.
  - Frame size constants NUM_COLUMNS/NUM_ROWS, shared with pattern_solver instances.
- Sub-module pixel_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, full, empty; async active-low reset. It is instantiated NUM_SOLVERS times.
- Arbiter and address counters stay in pixel_collector.

Test Plan:
- Bench configuration: NUM_SOLVERS=2, NUM_COLUMNS=4, NUM_ROWS=4, FIFO_DEPTH=4.
1. Single strobe: wr_ready=1, solver 0 strobes value 0x5 at cycle t -> wr_valid=1 at t+1, wr_addr=0, wr_data=0x5.
2. Address wrap: solver 1 strobes 5 times -> addresses 4,5,6,7,12 in order.
3. Fairness: both solvers strobe together on 4 consecutive cycles with wr_ready=1 -> writes alternate by solver: addresses 0,4,1,5,2,6,3,7; no overflow.
4. Backpressure and overflow: wr_ready=0, solver 0 strobes 6 times -> wr_valid held with addr 0. One register + 4 FIFO entries are kept, the 6th strobe is dropped, and overflow=1. Releasing wr_ready -> addresses 0,1,2,3,8 are written.
5. Full frame: both solvers produce all 16 pixels with wr_ready toggling randomly -> exactly 16 transfers covering addresses 0..15 once each. frame_done rises the cycle after the 16th transfer; overflow=0.
6. Reset and restart: assert reset low mid-frame -> all outputs 0 immediately. Pulse start with a same-cycle strobe -> the strobe is ignored, and the next strobe from solver 1 writes address 4.

Source files
------------

// File: rtl/pixel_collector_pkg.sv
//------------------------------------------------------------------------------
// pixel_collector_pkg : shared pixel and frame constants for the solver path
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pixel_collector_pkg;
    localparam int PIXEL_WIDTH   = 4;
    localparam int FB_ADDR_WIDTH = 19;
    localparam int NUM_COLUMNS   = 640;
    localparam int NUM_ROWS      = 480;
endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
//------------------------------------------------------------------------------
// pixel_fifo : synchronous FIFO holding {address, pixel} entries of one solver
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    import pixel_collector_pkg::*;

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    // Storage carries no reset; only entries below r_count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (c_AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pixel_collector.sv
//------------------------------------------------------------------------------
// pixel_collector : buffers row-interleaved solver results, arbitrates them
//                   round-robin and writes addressed pixels to the framebuffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_collector #(
    parameter int NUM_SOLVERS = 4,
    parameter int NUM_COLUMNS = pixel_collector_pkg::NUM_COLUMNS,
    parameter int NUM_ROWS    = pixel_collector_pkg::NUM_ROWS,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = pixel_collector_pkg::FB_ADDR_WIDTH
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [pixel_collector_pkg::PIXEL_WIDTH*NUM_SOLVERS-1:0] solver_out,
    input  logic [NUM_SOLVERS-1:0]                             solver_ready,
    output logic                                               wr_valid,
    input  logic                                               wr_ready,
    output logic [ADDR_WIDTH-1:0]                              wr_addr,
    output logic [pixel_collector_pkg::PIXEL_WIDTH-1:0]        wr_data,
    output logic                                               frame_done,
    output logic                                               overflow
);
    import pixel_collector_pkg::*;

    localparam int c_ENTRY_W = ADDR_WIDTH + PIXEL_WIDTH;
    localparam int c_COL_W   = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int c_PTR_W   = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam int c_TOTAL   = NUM_COLUMNS * NUM_ROWS;
    localparam int c_CNT_W   = $clog2(c_TOTAL + 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_STEP =
        ADDR_WIDTH'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);

    logic [c_ENTRY_W-1:0]   w_fifo_dout [NUM_SOLVERS];
    logic [c_ENTRY_W-1:0]   w_head      [NUM_SOLVERS];
    logic [NUM_SOLVERS-1:0] w_full, w_empty, w_push, w_pop, w_avail, w_grant, w_drop;
    logic [c_PTR_W-1:0]     r_ptr, w_sel, w_ptr_next;
    logic                   w_found, w_load, w_xfer;
    logic [c_CNT_W-1:0]     r_count;

    assign w_xfer = wr_valid && wr_ready;
    assign w_load = (!wr_valid || wr_ready) && !start;

    for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_solver
        logic [c_COL_W-1:0]    r_col;
        logic [ADDR_WIDTH-1:0] r_addr;
        logic [c_ENTRY_W-1:0]  w_entry;
        logic                  w_strobe, w_bypass;

        assign w_entry  = {r_addr, solver_out[i*PIXEL_WIDTH +: PIXEL_WIDTH]};
        assign w_strobe = solver_ready[i] && !start;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_col  <= '0;
                r_addr <= ADDR_WIDTH'(i * NUM_COLUMNS);
            end else if (start) begin
                r_col  <= '0;
                r_addr <= ADDR_WIDTH'(i * NUM_COLUMNS);
            end else if (solver_ready[i]) begin
                if (r_col == c_COL_W'(NUM_COLUMNS - 1)) begin
                    r_col  <= '0;
                    r_addr <= r_addr + c_ROW_STEP;
                end else begin
                    r_col  <= r_col + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end
            end
        end

        // An empty FIFO lets a fresh strobe go straight to the output register.
        assign w_avail[i] = !w_empty[i] || w_strobe;
        assign w_head[i]  = w_empty[i] ? w_entry : w_fifo_dout[i];
        assign w_bypass   = w_grant[i] && w_empty[i];
        assign w_pop[i]   = w_grant[i] && !w_empty[i];
        assign w_push[i]  = w_strobe && !w_bypass && (!w_full[i] || w_pop[i]);
        assign w_drop[i]  = w_strobe && !w_bypass && w_full[i] && !w_pop[i];

        pixel_fifo #(
            .WIDTH (c_ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .clear (start),
            .push  (w_push[i]),
            .pop   (w_pop[i]),
            .din   (w_entry),
            .dout  (w_fifo_dout[i]),
            .full  (w_full[i]),
            .empty (w_empty[i])
        );
    end

    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_sel      = r_ptr;
        w_grant    = '0;
        w_ptr_next = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_SOLVERS) idx = idx - NUM_SOLVERS;
            if (!w_found && w_avail[c_PTR_W'(idx)]) begin
                w_found = 1'b1;
                w_sel   = c_PTR_W'(idx);
            end
        end
        if (w_load && w_found) w_grant[w_sel] = 1'b1;
        if (int'(w_sel) != NUM_SOLVERS - 1) w_ptr_next = w_sel + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            r_ptr      <= '0;
            r_count    <= '0;
        end else if (start) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            r_ptr      <= '0;
            r_count    <= '0;
        end else begin
            if (w_load) begin
                wr_valid <= w_found;
                if (w_found) begin
                    {wr_addr, wr_data} <= w_head[w_sel];
                    r_ptr              <= w_ptr_next;
                end
            end
            if (w_xfer) begin
                r_count <= r_count + 1'b1;
                if (r_count == c_CNT_W'(c_TOTAL - 1)) frame_done <= 1'b1;
            end
            if (|w_drop) overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_collector.sv
//------------------------------------------------------------------------------
// tb_pixel_collector : directed self-checking bench for pixel_collector
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pixel_collector;
    localparam int NS = 2;
    localparam int NC = 4;
    localparam int NR = 4;
    localparam int FD = 4;
    localparam int AW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic [4*NS-1:0] solver_out;
    logic [NS-1:0] solver_ready;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          frame_done;
    logic          overflow;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int done_cycle = -1;
    logic [AW-1:0] xa [$];
    logic [3:0]    xd [$];
    int            xe [$];

    pixel_collector #(
        .NUM_SOLVERS (NS),
        .NUM_COLUMNS (NC),
        .NUM_ROWS    (NR),
        .FIFO_DEPTH  (FD),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .solver_out   (solver_out),
        .solver_ready (solver_ready),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Transfers happen on the next rising edge; record the edge index they complete on.
    always @(negedge clock) begin
        if (reset && wr_valid && wr_ready) begin
            xa.push_back(wr_addr);
            xd.push_back(wr_data);
            xe.push_back(cyc + 1);
        end
        if (reset && frame_done && done_cycle < 0) done_cycle = cyc;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start        = 1'b1;
        solver_ready = '0;
        step();
        start = 1'b0;
        xa.delete();
        xd.delete();
        xe.delete();
        done_cycle = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; wr_ready = 1'b0;
        solver_ready = '0; solver_out = '0;
        #3;
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", wr_valid); end
        vectors++; if (wr_addr !== 4'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 4'd0) begin miscompares++; $display("FAIL reset_data: got %0d want 0", wr_data); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", frame_done); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_start();
        wr_ready = 1'b1;
        solver_out = 8'h05; solver_ready = 2'b01;
        step();
        solver_ready = '0;
        vectors++; if (wr_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", wr_valid); end
        vectors++; if (wr_addr !== 4'd0) begin miscompares++; $display("FAIL single_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 4'h5) begin miscompares++; $display("FAIL single_data: got %0h want 5", wr_data); end
        step();
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b want 0", wr_valid); end
    endtask

    task automatic test_addr_wrap();
        int ea [5];
        ea = '{4, 5, 6, 7, 12};
        do_start();
        wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            solver_out = {4'(k + 1), 4'h0}; solver_ready = 2'b10;
            step();
        end
        solver_ready = '0;
        repeat (4) step();
        vectors++; if (xa.size() != 5) begin miscompares++; $display("FAIL wrap_count: got %0d want 5", xa.size()); end
        for (int k = 0; k < 5 && k < xa.size(); k++) begin
            vectors++;
            if (xa[k] !== 4'(ea[k]) || xd[k] !== 4'(k + 1)) begin
                miscompares++; $display("FAIL wrap_%0d: got addr %0d data %0d want addr %0d data %0d", k, xa[k], xd[k], ea[k], k + 1);
            end
        end
    endtask

    task automatic test_fairness();
        int ea [8];
        int ed [8];
        ea = '{0, 4, 1, 5, 2, 6, 3, 7};
        ed = '{0, 8, 1, 9, 2, 10, 3, 11};
        do_start();
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            solver_out = {4'(8 + k), 4'(k)}; solver_ready = 2'b11;
            step();
        end
        solver_ready = '0;
        repeat (8) step();
        vectors++; if (xa.size() != 8) begin miscompares++; $display("FAIL fair_count: got %0d want 8", xa.size()); end
        for (int k = 0; k < 8 && k < xa.size(); k++) begin
            vectors++;
            if (xa[k] !== 4'(ea[k]) || xd[k] !== 4'(ed[k])) begin
                miscompares++; $display("FAIL fair_%0d: got addr %0d data %0d want addr %0d data %0d", k, xa[k], xd[k], ea[k], ed[k]);
            end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fair_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        int ea [5];
        ea = '{0, 1, 2, 3, 8};
        do_start();
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            solver_out = {4'h0, 4'(k + 1)}; solver_ready = 2'b01;
            step();
            vectors++;
            if (wr_valid !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 4'd1 || overflow !== (k == 5)) begin
                miscompares++; $display("FAIL bp_hold_%0d: got v%b a%0d d%0d o%b want v1 a0 d1 o%0d", k, wr_valid, wr_addr, wr_data, overflow, k == 5);
            end
        end
        solver_ready = '0;
        wr_ready = 1'b1;
        repeat (8) step();
        vectors++; if (xa.size() != 5) begin miscompares++; $display("FAIL bp_count: got %0d want 5", xa.size()); end
        for (int k = 0; k < 5 && k < xa.size(); k++) begin
            vectors++;
            if (xa[k] !== 4'(ea[k]) || xd[k] !== 4'(k + 1)) begin
                miscompares++; $display("FAIL bp_%0d: got addr %0d data %0d want addr %0d data %0d", k, xa[k], xd[k], ea[k], k + 1);
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_frame();
        logic [15:0] seen;
        int bad;
        do_start();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NC; c++) begin
                solver_out   = {4'((r*8 + 4 + c) ^ 10), 4'((r*8 + c) ^ 10)};
                solver_ready = 2'b11;
                wr_ready     = 1'($urandom_range(0, 1));
                step();
                solver_ready = '0;
                repeat (5) begin
                    wr_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        end
        for (int n = 0; n < 300 && done_cycle < 0; n++) begin
            wr_ready = 1'($urandom_range(0, 1));
            step();
        end
        wr_ready = 1'b0;
        step();
        vectors++; if (done_cycle < 0) begin miscompares++; $display("FAIL frame_timeout: got done 0 after budget want 1"); end
        vectors++; if (xa.size() != 16) begin miscompares++; $display("FAIL frame_count: got %0d want 16", xa.size()); end
        seen = '0; bad = 0;
        for (int k = 0; k < xa.size(); k++) begin
            if (seen[xa[k]] || xd[k] !== (xa[k] ^ 4'hA)) bad++;
            seen[xa[k]] = 1'b1;
        end
        vectors++; if (bad != 0 || seen !== 16'hFFFF) begin miscompares++; $display("FAIL frame_cover: got seen %h bad %0d want seen ffff bad 0", seen, bad); end
        if (xe.size() == 16) begin
            vectors++; if (done_cycle != xe[15]) begin miscompares++; $display("FAIL frame_done_timing: got edge %0d want edge %0d", done_cycle, xe[15]); end
        end
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_done_level: got %b want 1", frame_done); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL frame_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_restart();
        do_start();
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            solver_out = 8'h0F; solver_ready = 2'b01;
            step();
        end
        solver_ready = '0;
        vectors++; if (overflow !== 1'b1 || wr_valid !== 1'b1) begin miscompares++; $display("FAIL rr_pre: got o%b v%b want o1 v1", overflow, wr_valid); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (wr_valid !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 4'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++; $display("FAIL rr_async: got v%b a%0d d%0d o%b f%b want all 0", wr_valid, wr_addr, wr_data, overflow, frame_done);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            solver_out = 8'h0F; solver_ready = 2'b01;
            step();
        end
        start = 1'b1; solver_out = 8'hFF; solver_ready = 2'b11;
        step();
        start = 1'b0; solver_ready = '0;
        vectors++; if (wr_valid !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL rr_start_clear: got v%b o%b want v0 o0", wr_valid, overflow); end
        wr_ready = 1'b1;
        solver_out = 8'h30; solver_ready = 2'b10;
        step();
        vectors++; if (wr_valid !== 1'b1 || wr_addr !== 4'd4 || wr_data !== 4'd3) begin miscompares++; $display("FAIL rr_s1: got v%b a%0d d%0d want v1 a4 d3", wr_valid, wr_addr, wr_data); end
        solver_out = 8'h06; solver_ready = 2'b01;
        step();
        solver_ready = '0;
        vectors++; if (wr_valid !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 4'd6) begin miscompares++; $display("FAIL rr_s0: got v%b a%0d d%0d want v1 a0 d6", wr_valid, wr_addr, wr_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr_wrap();
        test_fairness();
        test_backpressure();
        test_full_frame();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

`default_nettype wire
